// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if
//   Bundles the instruction fetch unit's two handshakes: the word-read
//   channel to instruction memory and the instruction/redirect channel to
//   the decoder/datapath.
//   master : the fetch unit (drives imem_req/imem_addr and inst/inst_pc/inst_valid)
//   slave  : the environment (memory + decoder/datapath)
//   Signals:
//     imem_req, imem_addr      fetch -> memory  read request, word address
//     imem_ack, imem_rdata     memory -> fetch  read done, instruction word
//     inst, inst_pc,
//     inst_valid               fetch -> decoder head instruction and its PC
//     inst_ready               datapath -> fetch consume the head this cycle
//     jump, branch, bne, zero  decoder/ALU -> fetch redirect qualifiers
// ---------------------------------------------------------------------------
interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        jump;
    logic        branch;
    logic        bne;
    logic        zero;

    modport master (
        output imem_req, imem_addr, inst, inst_pc, inst_valid,
        input  imem_ack, imem_rdata, inst_ready, jump, branch, bne, zero
    );

    modport slave (
        input  imem_req, imem_addr, inst, inst_pc, inst_valid,
        output imem_ack, imem_rdata, inst_ready, jump, branch, bne, zero
    );
endinterface

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch unit. Sequences the fetch PC, issues word reads to
//   instruction memory over a req/ack handshake, buffers returned words in a
//   DEPTH-entry prefetch queue and presents the head instruction with its PC
//   to the decoder. Taken jumps/branches at consume time flush the queue and
//   restart fetching at the target; a read already in flight is dropped.
//
//   Parameters:
//     DEPTH     prefetch queue entries (power of two, >= 2)
//     RESET_PC  first fetch address after reset
//   Ports:
//     clk       rising-edge clock
//     rst       asynchronous, active-high reset
//     bus       inst_fetch_if.master (memory + decoder channels)
//
//   Optional feature (macro IFETCH_BYPASS_EN): when defined, a word acked
//   while the queue is empty is presented on inst/inst_pc/inst_valid in the
//   ack cycle itself and, if consumed, is never enqueued. Undefined (the
//   default), all decoder-facing outputs come straight from registers.
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_e;

    // Registered state
    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     count_q, count_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   q_inst_q [DEPTH];
    logic [XLEN-1:0]   q_inst_d [DEPTH];
    logic [XLEN-1:0]   q_pc_q   [DEPTH];
    logic [XLEN-1:0]   q_pc_d   [DEPTH];

    // Head view seen by the decoder
    logic              bypass_c;
    logic [XLEN-1:0]   head_inst_c;
    logic [XLEN-1:0]   head_pc_c;
    logic              head_valid_c;

    // Handshake / redirect decode
    logic              consume_c;
    logic              taken_c;
    logic              q_pop_c;
    logic              push_c;
    logic [XLEN-1:0]   pc4_c;
    logic [XLEN-1:0]   jump_tgt_c;
    logic [XLEN-1:0]   branch_tgt_c;
    logic [XLEN-1:0]   target_c;
    logic [AW-1:0]     wr_idx_c;

    // Head selection: queue entry 0, or the in-flight word when bypassing
`ifdef IFETCH_BYPASS_EN
    assign bypass_c     = (count_q == '0) && (state_q == S_REQ) && bus.imem_ack;
    assign head_inst_c  = bypass_c ? bus.imem_rdata : q_inst_q[0];
    assign head_pc_c    = bypass_c ? addr_q         : q_pc_q[0];
    assign head_valid_c = valid_q | bypass_c;
`else
    assign bypass_c     = 1'b0;
    assign head_inst_c  = q_inst_q[0];
    assign head_pc_c    = q_pc_q[0];
    assign head_valid_c = valid_q;
`endif

    assign bus.inst       = head_inst_c;
    assign bus.inst_pc    = head_pc_c;
    assign bus.inst_valid = head_valid_c;
    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;

    // Redirect target computation for the head instruction
    assign pc4_c        = head_pc_c + 32'd4;
    assign jump_tgt_c   = {pc4_c[31:28], head_inst_c[25:0], 2'b00};
    assign branch_tgt_c = pc4_c + {{14{head_inst_c[15]}}, head_inst_c[15:0], 2'b00};
    assign target_c     = bus.jump ? jump_tgt_c : branch_tgt_c;

    assign consume_c = head_valid_c & bus.inst_ready;
    assign taken_c   = consume_c &
                       (bus.jump | (bus.branch & bus.zero) | (bus.bne & ~bus.zero));

    // A bypassed word consumed in its ack cycle never touches the queue
    assign q_pop_c = consume_c & ~bypass_c;
    assign push_c  = (state_q == S_REQ) & bus.imem_ack & ~taken_c &
                     ~(bypass_c & consume_c);

    // Credit rule guarantees the write slot is below DEPTH
    assign wr_idx_c = AW'(count_q - CW'(q_pop_c));

    // Next-state logic: queue, fetch PC and fetch FSM
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        q_inst_d   = q_inst_q;
        q_pc_d     = q_pc_q;

        // Shift-register queue: entry 0 is always the head
        if (q_pop_c) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                q_inst_d[i] = q_inst_q[i+1];
                q_pc_d[i]   = q_pc_q[i+1];
            end
        end
        if (push_c) begin
            q_inst_d[wr_idx_c] = bus.imem_rdata;
            q_pc_d[wr_idx_c]   = addr_q;
        end

        if (taken_c) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push_c) - CW'(q_pop_c);
        end

        if ((state_q == S_REQ) && bus.imem_ack) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (taken_c) begin
            fetch_pc_d = target_c;
        end

        // A new request is launched only while queue + outstanding < DEPTH
        unique case (state_q)
            S_IDLE: begin
                if (count_d < CW'(DEPTH)) begin
                    state_d = S_REQ;
                    addr_d  = fetch_pc_d;
                end
            end
            S_REQ: begin
                if (bus.imem_ack) begin
                    if (count_d < CW'(DEPTH)) begin
                        state_d = S_REQ;
                        addr_d  = fetch_pc_d;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (taken_c) begin
                    // Keep the stale request alive (address held) until acked
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.imem_ack) begin
                    state_d = S_REQ;
                    addr_d  = fetch_pc_d;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_d   = (state_d != S_IDLE);
        valid_d = (count_d != '0);
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            valid_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_inst_q[i] <= '0;
                q_pc_q[i]   <= RESET_PC;
            end
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            q_inst_q   <= q_inst_d;
            q_pc_q     <= q_pc_d;
        end
    end

    // A push must never land on a full queue
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push_c |-> (count_q < CW'(DEPTH)));

endmodule
